// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: reset level, register and
// data constants, memory aluop codes and byte-enable patterns.
package mem_access_pkg;

    localparam logic        RstEnable  = 1'b1;
    localparam logic [4:0]  NOPRegAddr = 5'b00000;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_ALL  = 4'b1111;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_B1   = 4'b0010;
    localparam logic [3:0] BE_B2   = 4'b0100;
    localparam logic [3:0] BE_B3   = 4'b1000;
    localparam logic [3:0] BE_H_LO = 4'b0011;
    localparam logic [3:0] BE_H_HI = 4'b1100;

    function automatic logic is_load_op(input logic [7:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP);
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// Combinational lane logic: load byte/halfword extraction with sign or zero
// extension, store byte-enable and lane-replicated write data, and the
// alignment check for the presented op.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [7:0]  aluop_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] reg2_i,
    output logic        is_load_o,
    output logic        is_store_o,
    output logic        misalign_o,
    output logic [31:0] ld_data_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign is_load_o  = is_load_op(aluop_i);
    assign is_store_o = is_store_op(aluop_i);

    // Select the addressed byte and halfword lanes of the read word.
    always_comb begin
        rd_byte = rdata_i[7:0];
        case (addr_lo_i)
            2'd0: rd_byte = rdata_i[7:0];
            2'd1: rd_byte = rdata_i[15:8];
            2'd2: rd_byte = rdata_i[23:16];
            2'd3: rd_byte = rdata_i[31:24];
            default: rd_byte = rdata_i[7:0];
        endcase
        rd_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Per-op formatting; loads always request the whole word.
    always_comb begin
        ld_data_o  = ZeroWord;
        be_o       = BE_NONE;
        wdata_o    = ZeroWord;
        misalign_o = 1'b0;
        case (aluop_i)
            EXE_LB_OP: begin
                ld_data_o = {{24{rd_byte[7]}}, rd_byte};
                be_o      = BE_ALL;
            end
            EXE_LBU_OP: begin
                ld_data_o = {24'h0, rd_byte};
                be_o      = BE_ALL;
            end
            EXE_LH_OP: begin
                misalign_o = addr_lo_i[0];
                ld_data_o  = {{16{rd_half[15]}}, rd_half};
                be_o       = BE_ALL;
            end
            EXE_LHU_OP: begin
                misalign_o = addr_lo_i[0];
                ld_data_o  = {16'h0, rd_half};
                be_o       = BE_ALL;
            end
            EXE_LW_OP: begin
                misalign_o = |addr_lo_i;
                ld_data_o  = rdata_i;
                be_o       = BE_ALL;
            end
            EXE_SB_OP: begin
                case (addr_lo_i)
                    2'd0: be_o = BE_B0;
                    2'd1: be_o = BE_B1;
                    2'd2: be_o = BE_B2;
                    2'd3: be_o = BE_B3;
                    default: be_o = BE_NONE;
                endcase
                wdata_o = {4{reg2_i[7:0]}};
            end
            EXE_SH_OP: begin
                misalign_o = addr_lo_i[0];
                be_o       = addr_lo_i[1] ? BE_H_HI : BE_H_LO;
                wdata_o    = {2{reg2_i[15:0]}};
            end
            EXE_SW_OP: begin
                misalign_o = |addr_lo_i;
                be_o       = BE_ALL;
                wdata_o    = reg2_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: runs loads/stores over a req/gnt/rvalid bus
// and stalls the pipeline while a transaction is outstanding.
//
// state | meaning
// IDLE  | no transaction; an aligned memory op launches the request
// REQ   | dbus_req held with stable address/be/we/wdata until gnt
// WAIT  | load granted, waiting for rvalid to capture read data
// DONE  | result presented to MEM/WB, pipeline advances this edge
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [7:0]        mem_aluop,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_reg2,
    output logic [4:0]        wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              stallreq,
    output logic              misalign_ld,
    output logic              misalign_st,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [3:0]        dbus_be,
    output logic [DATA_W-1:0] dbus_wdata,
    input  logic              dbus_gnt,
    input  logic              dbus_rvalid,
    input  logic [DATA_W-1:0] dbus_rdata
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_e;

    state_e            state_q, state_d;
    logic              dbus_req_q, dbus_req_d;
    logic              dbus_we_q, dbus_we_d;
    logic [ADDR_W-1:0] dbus_addr_q, dbus_addr_d;
    logic [3:0]        dbus_be_q, dbus_be_d;
    logic [DATA_W-1:0] dbus_wdata_q, dbus_wdata_d;
    logic [DATA_W-1:0] ld_data_q, ld_data_d;

    logic              al_is_load, al_is_store, al_misalign;
    logic [31:0]       al_ld_data, al_wdata;
    logic [3:0]        al_be;
    logic              start_op;

    mem_align u_align (
        .aluop_i    (mem_aluop),
        .addr_lo_i  (mem_addr[1:0]),
        .rdata_i    (dbus_rdata),
        .reg2_i     (mem_reg2),
        .is_load_o  (al_is_load),
        .is_store_o (al_is_store),
        .misalign_o (al_misalign),
        .ld_data_o  (al_ld_data),
        .be_o       (al_be),
        .wdata_o    (al_wdata)
    );

    assign start_op = (al_is_load || al_is_store) && !al_misalign;

    // State and bus registers; reset also abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q      <= IDLE;
            dbus_req_q   <= 1'b0;
            dbus_we_q    <= 1'b0;
            dbus_addr_q  <= '0;
            dbus_be_q    <= BE_NONE;
            dbus_wdata_q <= '0;
            ld_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            dbus_req_q   <= dbus_req_d;
            dbus_we_q    <= dbus_we_d;
            dbus_addr_q  <= dbus_addr_d;
            dbus_be_q    <= dbus_be_d;
            dbus_wdata_q <= dbus_wdata_d;
            ld_data_q    <= ld_data_d;
        end
    end

    // Next-state and bus launch/handshake.
    always_comb begin
        state_d      = state_q;
        dbus_req_d   = dbus_req_q;
        dbus_we_d    = dbus_we_q;
        dbus_addr_d  = dbus_addr_q;
        dbus_be_d    = dbus_be_q;
        dbus_wdata_d = dbus_wdata_q;
        ld_data_d    = ld_data_q;
        case (state_q)
            IDLE: begin
                if (start_op) begin
                    state_d      = REQ;
                    dbus_req_d   = 1'b1;
                    dbus_we_d    = al_is_store;
                    dbus_addr_d  = {mem_addr[ADDR_W-1:2], 2'b00};
                    dbus_be_d    = al_be;
                    dbus_wdata_d = al_wdata;
                end
            end
            REQ: begin
                if (dbus_gnt) begin
                    dbus_req_d = 1'b0;
                    state_d    = dbus_we_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (dbus_rvalid) begin
                    ld_data_d = al_ld_data;
                    state_d   = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Writeback bundle, stall and misalignment flags.
    always_comb begin
        wb_wd       = mem_wd;
        wb_wreg     = mem_wreg;
        wb_wdata    = mem_wdata;
        stallreq    = 1'b0;
        misalign_ld = al_is_load && al_misalign;
        misalign_st = al_is_store && al_misalign;
        if (misalign_ld || misalign_st) begin
            wb_wreg = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (start_op) begin
                    stallreq = 1'b1;
                    wb_wreg  = 1'b0;
                end
            end
            REQ, WAIT: begin
                stallreq = 1'b1;
                wb_wreg  = 1'b0;
            end
            DONE: begin
                if (al_is_load) begin
                    wb_wdata = ld_data_q;
                end else if (al_is_store) begin
                    wb_wreg = 1'b0;
                end
            end
            default: ;
        endcase
        if (rst == RstEnable) begin
            wb_wd       = NOPRegAddr;
            wb_wreg     = 1'b0;
            wb_wdata    = '0;
            stallreq    = 1'b0;
            misalign_ld = 1'b0;
            misalign_st = 1'b0;
        end
    end

    assign dbus_req   = dbus_req_q;
    assign dbus_we    = dbus_we_q;
    assign dbus_addr  = dbus_addr_q;
    assign dbus_be    = dbus_be_q;
    assign dbus_wdata = dbus_wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed ops push expected writeback and
// bus transactions; a retire monitor and the bus responder pop and compare.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_addr;
    logic [31:0] mem_reg2;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        stallreq, misalign_ld, misalign_st;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_gnt, dbus_rvalid;
    logic [31:0] dbus_rdata;

    localparam logic [7:0] EXE_OR_OP = 8'b0010_0101;
    localparam logic [7:0] NOP_OP    = 8'h00;

    mem_access dut (
        .clk(clk), .rst(rst),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_aluop(mem_aluop), .mem_addr(mem_addr), .mem_reg2(mem_reg2),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .stallreq(stallreq), .misalign_ld(misalign_ld), .misalign_st(misalign_st),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
        .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        chk_wdata;
        logic        mis_ld;
        logic        mis_st;
        int          stalls;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic        chk_wdata;
    } bus_exp_t;

    wb_exp_t  wb_q[$];
    bus_exp_t bus_q[$];
    int       n_chk = 0;
    int       n_fail = 0;
    logic     op_active = 1'b0;
    int       gnt_dly = 0;
    int       rv_dly = 1;
    logic [31:0] rdata_cfg = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_wb(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                          input logic chk, input logic mld, input logic mst, input int stalls);
        wb_exp_t e;
        e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.chk_wdata = chk;
        e.mis_ld = mld; e.mis_st = mst; e.stalls = stalls;
        wb_q.push_back(e);
    endtask

    task automatic exp_bus(input logic [31:0] addr, input logic [3:0] be, input logic we,
                           input logic [31:0] wdata, input logic chk);
        bus_exp_t b;
        b.addr = addr; b.be = be; b.we = we; b.wdata = wdata; b.chk_wdata = chk;
        bus_q.push_back(b);
    endtask

    // Present one op and hold it until the stage stops stalling.
    task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [4:0] wd, input logic wreg, input logic [31:0] alu,
                         input logic [31:0] rdata, input int gd, input int rd);
        bit done;
        mem_aluop = op; mem_addr = addr; mem_reg2 = reg2;
        mem_wd = wd; mem_wreg = wreg; mem_wdata = alu;
        gnt_dly = gd; rv_dly = rd; rdata_cfg = rdata;
        op_active = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!stallreq) begin
                done = 1'b1;
                break;
            end
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL retire_timeout: op 0x%02h still stalling", op);
        end
        @(posedge clk);
        #1;
    endtask

    // Retire monitor: counts stall cycles and checks the writeback bundle.
    int stall_seen = 0;
    always @(negedge clk) begin
        wb_exp_t e;
        if (op_active && !rst) begin
            if (stallreq) begin
                stall_seen++;
            end else begin
                if (wb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL wb_unexpected: retire with empty scoreboard at %0t", $time);
                end else begin
                    e = wb_q.pop_front();
                    check("wb_wd", 32'(wb_wd), 32'(e.wd));
                    check("wb_wreg", 32'(wb_wreg), 32'(e.wreg));
                    if (e.chk_wdata) check("wb_wdata", wb_wdata, e.wdata);
                    check("misalign_ld", 32'(misalign_ld), 32'(e.mis_ld));
                    check("misalign_st", 32'(misalign_st), 32'(e.mis_st));
                    check("stall_cycles", 32'(stall_seen), 32'(e.stalls));
                end
                stall_seen = 0;
            end
        end
    end

    // Bus responder: grants after gnt_dly request cycles, returns read data
    // rv_dly cycles after the grant, and checks each granted request.
    logic gnt_given = 1'b0;
    int   g_cnt = 0;
    logic rv_pending = 1'b0;
    int   rv_cnt = 0;
    initial begin
        bus_exp_t b;
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'h0;
        forever begin
            @(negedge clk);
            dbus_gnt = 1'b0;
            dbus_rvalid = 1'b0;
            if (rv_pending) begin
                if (rv_cnt == 0) begin
                    dbus_rvalid = 1'b1;
                    dbus_rdata = rdata_cfg;
                    rv_pending = 1'b0;
                end else begin
                    rv_cnt--;
                end
            end
            if (!dbus_req) begin
                gnt_given = 1'b0;
                g_cnt = gnt_dly;
            end else if (!gnt_given) begin
                if (g_cnt == 0) begin
                    dbus_gnt = 1'b1;
                    gnt_given = 1'b1;
                    if (bus_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL bus_unexpected_req: addr 0x%08h at %0t", dbus_addr, $time);
                    end else begin
                        b = bus_q.pop_front();
                        check("dbus_addr", dbus_addr, b.addr);
                        check("dbus_be", 32'(dbus_be), 32'(b.be));
                        check("dbus_we", 32'(dbus_we), 32'(b.we));
                        if (b.chk_wdata) check("dbus_wdata", dbus_wdata, b.wdata);
                    end
                    if (!dbus_we) begin
                        rv_pending = 1'b1;
                        rv_cnt = rv_dly - 1;
                    end
                end else begin
                    g_cnt--;
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        mem_aluop = EXE_LW_OP; mem_addr = 32'h301; mem_reg2 = 32'h0;
        mem_wd = 5'd7; mem_wreg = 1'b1; mem_wdata = 32'hFFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wb_wd", 32'(wb_wd), 32'd0);
        check("rst_wb_wreg", 32'(wb_wreg), 32'd0);
        check("rst_wb_wdata", wb_wdata, 32'd0);
        check("rst_stallreq", 32'(stallreq), 32'd0);
        check("rst_misalign_ld", 32'(misalign_ld), 32'd0);
        check("rst_dbus_req", 32'(dbus_req), 32'd0);
        check("rst_dbus_addr", dbus_addr, 32'd0);
        check("rst_dbus_be", 32'(dbus_be), 32'd0);
        @(posedge clk);
        #1;
        mem_aluop = NOP_OP;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ALU passthrough
        exp_wb(5'd3, 1'b1, 32'h1234, 1'b1, 1'b0, 1'b0, 0);
        issue(EXE_OR_OP, 32'h0, 32'h0, 5'd3, 1'b1, 32'h1234, 32'h0, 0, 1);
        // LB / LBU of byte 3
        exp_bus(32'h100, 4'hF, 1'b0, 32'h0, 1'b0);
        exp_wb(5'd5, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0, 3);
        issue(EXE_LB_OP, 32'h103, 32'h0, 5'd5, 1'b1, 32'hAAAA, 32'h80FF_0011, 0, 1);
        exp_bus(32'h100, 4'hF, 1'b0, 32'h0, 1'b0);
        exp_wb(5'd5, 1'b1, 32'h0000_0080, 1'b1, 1'b0, 1'b0, 3);
        issue(EXE_LBU_OP, 32'h103, 32'h0, 5'd5, 1'b1, 32'hAAAA, 32'h80FF_0011, 0, 1);
        // SH upper half with gnt delayed 3 cycles
        exp_bus(32'h200, 4'hC, 1'b1, 32'hBEEF_BEEF, 1'b1);
        exp_wb(5'd6, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5);
        issue(EXE_SH_OP, 32'h202, 32'hAAAA_BEEF, 5'd6, 1'b1, 32'h202, 32'h0, 3, 1);
        // misaligned LW and SH
        exp_wb(5'd8, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 0);
        issue(EXE_LW_OP, 32'h301, 32'h0, 5'd8, 1'b1, 32'h301, 32'h0, 0, 1);
        exp_wb(5'd9, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 0);
        issue(EXE_SH_OP, 32'h203, 32'h1111, 5'd9, 1'b1, 32'h203, 32'h0, 0, 1);
        // LH / LHU
        exp_bus(32'h100, 4'hF, 1'b0, 32'h0, 1'b0);
        exp_wb(5'd11, 1'b1, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0, 3);
        issue(EXE_LH_OP, 32'h102, 32'h0, 5'd11, 1'b1, 32'h0, 32'h8001_7FFF, 0, 1);
        exp_bus(32'h100, 4'hF, 1'b0, 32'h0, 1'b0);
        exp_wb(5'd12, 1'b1, 32'h0000_7FFF, 1'b1, 1'b0, 1'b0, 3);
        issue(EXE_LHU_OP, 32'h100, 32'h0, 5'd12, 1'b1, 32'h0, 32'h8001_7FFF, 0, 1);
        // SB lane 1
        exp_bus(32'h100, 4'h2, 1'b1, 32'h5555_5555, 1'b1);
        exp_wb(5'd13, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2);
        issue(EXE_SB_OP, 32'h101, 32'h1234_5655, 5'd13, 1'b1, 32'h0, 32'h0, 0, 1);
        // LW then SW back-to-back, gnt one cycle late
        exp_bus(32'h400, 4'hF, 1'b0, 32'h0, 1'b0);
        exp_wb(5'd14, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 4);
        issue(EXE_LW_OP, 32'h400, 32'h0, 5'd14, 1'b1, 32'h0, 32'hDEAD_BEEF, 1, 1);
        exp_bus(32'h404, 4'hF, 1'b1, 32'h1234_5678, 1'b1);
        exp_wb(5'd15, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3);
        issue(EXE_SW_OP, 32'h404, 32'h1234_5678, 5'd15, 1'b1, 32'h0, 32'h0, 1, 1);
        // LB lane 2 with slow read data
        exp_bus(32'h100, 4'hF, 1'b0, 32'h0, 1'b0);
        exp_wb(5'd16, 1'b1, 32'hFFFF_FFAB, 1'b1, 1'b0, 1'b0, 5);
        issue(EXE_LB_OP, 32'h102, 32'h0, 5'd16, 1'b1, 32'h0, 32'h00AB_0000, 0, 3);

        // reset while waiting for read data; rvalid arrives after reset
        op_active = 1'b0;
        exp_bus(32'h500, 4'hF, 1'b0, 32'h0, 1'b0);
        mem_aluop = EXE_LW_OP; mem_addr = 32'h500; mem_wd = 5'd10; mem_wreg = 1'b1;
        gnt_dly = 0; rv_dly = 2; rdata_cfg = 32'h1122_3344;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstw_stallreq", 32'(stallreq), 32'd0);
        check("rstw_wb_wreg", 32'(wb_wreg), 32'd0);
        @(posedge clk);
        #1;
        mem_aluop = NOP_OP;
        @(negedge clk);
        check("rstw_rvalid_seen", 32'(dbus_rvalid), 32'd1);
        check("rstw_state_idle", 32'(dut.state_q), 32'd0);
        check("rstw_dbus_req", 32'(dbus_req), 32'd0);
        check("rstw_dbus_addr", dbus_addr, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstw_ld_data_q", dut.ld_data_q, 32'd0);
        check("rstw_idle_stall", 32'(stallreq), 32'd0);
        check("rstw_idle_req", 32'(dbus_req), 32'd0);

        repeat (3) @(negedge clk);
        check("wb_queue_empty", 32'(wb_q.size()), 32'd0);
        check("bus_queue_empty", 32'(bus_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
